// File: rtl/mips32_pkg.sv
// Shared definitions for the single-cycle MIPS32-subset core: opcodes,
// ALU operation encoding, instruction field positions and decode helpers.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_MUL = 3'd5
  } alu_op_e;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op <= OP_MUL);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BNEQZ) || (op == OP_BEQZ);
  endfunction

endpackage

// File: rtl/mips32_decoder.sv
// Opcode to control-signal decode. Unknown opcodes decode to a NOP
// (no register, memory or halt side effects; pc simply advances).
module mips32_decoder
  import mips32_pkg::*;
(
  input  logic [5:0] op,
  output alu_op_e    alu_op,
  output logic       alu_src_imm,
  output logic       reg_dst_rd,
  output logic       reg_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       branch_eqz,
  output logic       branch_neqz,
  output logic       halt
);

  // Decode the opcode into datapath controls; defaults describe a NOP.
  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_dst_rd  = 1'b0;
    reg_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    branch_eqz  = 1'b0;
    branch_neqz = 1'b0;
    halt        = 1'b0;
    if (is_rtype(op)) begin
      // R-type opcodes 0..5 line up one-to-one with the ALU encoding.
      alu_op     = alu_op_e'(op[2:0]);
      reg_dst_rd = 1'b1;
      reg_wr     = 1'b1;
    end else if (is_branch(op)) begin
      branch_eqz  = (op == OP_BEQZ);
      branch_neqz = (op == OP_BNEQZ);
    end else begin
      case (op)
        OP_ADDI: begin alu_op = ALU_ADD; alu_src_imm = 1'b1; reg_wr = 1'b1; end
        OP_SUBI: begin alu_op = ALU_SUB; alu_src_imm = 1'b1; reg_wr = 1'b1; end
        OP_SLTI: begin alu_op = ALU_SLT; alu_src_imm = 1'b1; reg_wr = 1'b1; end
        OP_LW:   begin alu_src_imm = 1'b1; reg_wr = 1'b1; mem_rd = 1'b1; end
        OP_SW:   begin alu_src_imm = 1'b1; mem_wr = 1'b1; end
        OP_HLT:  halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips32_single_cycle_core.sv
// Single-cycle MIPS32-subset core: PC, register file, instruction and data
// memories, ALU and next-pc logic. Optional debug read port on the register
// file is enabled by defining MIPS32_DBG_PORT_EN.
module mips32_single_cycle_core
  import mips32_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        clr_PC,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        halted
`ifdef MIPS32_DBG_PORT_EN
  ,
  input  logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_data
`endif
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
  localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, wb_addr;
  logic [31:0] imm_sext, rs_val, rt_val, alu_b, alu_result;
  logic [31:0] dmem_rdata, wb_data, next_pc;
  logic        retire, br_taken;

  alu_op_e alu_op;
  logic    alu_src_imm, reg_dst_rd, reg_wr, mem_rd, mem_wr;
  logic    branch_eqz, branch_neqz, halt;

  // Side effects only while out of reset and not yet halted.
  assign retire = clr_PC && !halted;

  // Storage lives in named blocks so imem.mem, dmem.mem and regs.reg_bank
  // are reachable by hierarchical name.
  if (1'b1) begin : imem
    logic [31:0] mem [IMEM_WORDS];
  end

  assign instr    = imem.mem[pc[IMEM_AW-1:0]];
  assign op       = instr[OP_MSB:OP_LSB];
  assign rs       = instr[RS_MSB:RS_LSB];
  assign rt       = instr[RT_MSB:RT_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign imm_sext = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:0]};

  mips32_decoder u_decoder (
    .op          (op),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .reg_dst_rd  (reg_dst_rd),
    .reg_wr      (reg_wr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .branch_eqz  (branch_eqz),
    .branch_neqz (branch_neqz),
    .halt        (halt)
  );

  if (1'b1) begin : regs
    logic [31:0] reg_bank [32];

    // Register write-back; R0 is never written.
    always_ff @(posedge clk) begin
      if (retire && reg_wr && (wb_addr != '0)) begin
        reg_bank[wb_addr] <= wb_data;
      end
    end
  end

  assign rs_val = (rs == '0) ? '0 : regs.reg_bank[rs];
  assign rt_val = (rt == '0) ? '0 : regs.reg_bank[rt];

`ifdef MIPS32_DBG_PORT_EN
  assign dbg_reg_data = (dbg_reg_addr == '0) ? '0 : regs.reg_bank[dbg_reg_addr];
`endif

  assign alu_b = alu_src_imm ? imm_sext : rt_val;

  // 32-bit wrap-around ALU; SLT compares signed.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = rs_val + alu_b;
      ALU_SUB: alu_result = rs_val - alu_b;
      ALU_AND: alu_result = rs_val & alu_b;
      ALU_OR:  alu_result = rs_val | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_MUL: alu_result = rs_val * alu_b;
      default: alu_result = '0;
    endcase
  end

  if (1'b1) begin : dmem
    logic [31:0] mem [DMEM_WORDS];

    // Store on the retiring edge; address wraps to the memory depth.
    always_ff @(posedge clk) begin
      if (retire && mem_wr) begin
        mem[alu_result[DMEM_AW-1:0]] <= rt_val;
      end
    end
  end

  assign dmem_rdata = dmem.mem[alu_result[DMEM_AW-1:0]];
  assign wb_data    = mem_rd ? dmem_rdata : alu_result;
  assign wb_addr    = reg_dst_rd ? rd : rt;

  assign br_taken = (branch_eqz && (rs_val == '0)) || (branch_neqz && (rs_val != '0));

  // HLT keeps pc on itself so the frozen pc points at the halt instruction.
  always_comb begin
    next_pc = pc + 32'd1;
    if (halt) begin
      next_pc = pc;
    end else if (br_taken) begin
      next_pc = pc + 32'd1 + imm_sext;
    end
  end

  // PC and halt flag; reset overrides any instruction in the same cycle.
  always_ff @(posedge clk) begin
    if (!clr_PC) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      pc <= next_pc;
      if (halt) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips32_single_cycle_core.sv
// Self-checking bench for mips32_single_cycle_core: directed programs with
// constant expectations plus random programs run against an instruction-level
// reference model.
module tb_mips32_single_cycle_core;

  localparam logic [5:0] T_ADD = 6'd0, T_SUB = 6'd1, T_AND = 6'd2, T_OR = 6'd3,
                         T_SLT = 6'd4, T_MUL = 6'd5, T_LW = 6'd8, T_SW = 6'd9,
                         T_ADDI = 6'd10, T_SUBI = 6'd11, T_SLTI = 6'd12,
                         T_BNEQZ = 6'd13, T_BEQZ = 6'd14, T_HLT = 6'd63;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        clr_PC = 1'b1;
  logic [31:0] pc, instr;
  logic        halted;
`ifdef MIPS32_DBG_PORT_EN
  logic [4:0]  dbg_reg_addr = '0;
  logic [31:0] dbg_reg_data;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] m_imem [1024];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_halt;

  mips32_single_cycle_core dut (
    .clk    (clk),
    .clr_PC (clr_PC),
    .pc     (pc),
    .instr  (instr),
    .halted (halted)
`ifdef MIPS32_DBG_PORT_EN
    ,
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load program (HLT fill), randomise regs/dmem in DUT and model, reset one edge.
  task automatic setup(input logic [31:0] prog[$]);
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = (i < prog.size()) ? prog[i] : HLT_W;
      dut.imem.mem[i] = w;
      m_imem[i] = w;
      w = $urandom;
      dut.dmem.mem[i] = w;
      m_dmem[i] = w;
    end
    for (int i = 0; i < 32; i++) begin
      w = ($urandom_range(0, 2) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      dut.regs.reg_bank[i] = w;
      m_regs[i] = (i == 0) ? 32'd0 : w;
    end
    clr_PC = 1'b0;
    tick();
    clr_PC = 1'b1;
    m_pc = '0;
    m_halt = 1'b0;
  endtask

  // Instruction-set-level reference: execute one instruction on the model state.
  task automatic model_step();
    logic [31:0] w, a, b, s, ea;
    logic [5:0]  op;
    logic [4:0]  rt, rd;
    if (m_halt) return;
    w  = m_imem[m_pc[9:0]];
    op = w[31:26];
    rt = w[20:16];
    rd = w[15:11];
    a  = m_regs[w[25:21]];
    b  = m_regs[rt];
    s  = {{16{w[15]}}, w[15:0]};
    ea = a + s;
    case (op)
      T_ADD:   if (rd != 0) m_regs[rd] = a + b;
      T_SUB:   if (rd != 0) m_regs[rd] = a - b;
      T_AND:   if (rd != 0) m_regs[rd] = a & b;
      T_OR:    if (rd != 0) m_regs[rd] = a | b;
      T_SLT:   if (rd != 0) m_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      T_MUL:   if (rd != 0) m_regs[rd] = a * b;
      T_ADDI:  if (rt != 0) m_regs[rt] = a + s;
      T_SUBI:  if (rt != 0) m_regs[rt] = a - s;
      T_SLTI:  if (rt != 0) m_regs[rt] = ($signed(a) < $signed(s)) ? 32'd1 : 32'd0;
      T_LW:    if (rt != 0) m_regs[rt] = m_dmem[ea[9:0]];
      T_SW:    m_dmem[ea[9:0]] = b;
      default: ;
    endcase
    if (op == T_HLT) begin
      m_halt = 1'b1;
    end else if ((op == T_BEQZ && a == 0) || (op == T_BNEQZ && a != 0)) begin
      m_pc = m_pc + 1 + s;
    end else begin
      m_pc = m_pc + 1;
    end
  endtask

  task automatic fact_prog(output logic [31:0] p[$]);
    p = '{32'h200100c8, 32'h28020001, 32'h14411000, 32'h2c210001,
          32'h3420fffd, 32'h240200c6, 32'hfc000000};
  endtask

  task automatic test_reset();
    logic [31:0] p[$];
    p = '{enc_i(T_SW, 5'd0, 5'd1, 16'd5)};
    setup(p);
    vectors++;
    if (pc !== 32'd0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%0d halted=%b, expected pc=0 halted=0", pc, halted);
    end
    dut.regs.reg_bank[1] = 32'hDEAD_BEEF;
    dut.dmem.mem[5] = 32'h0000_1111;
    clr_PC = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (pc !== 32'd0 || halted !== 1'b0 || dut.dmem.mem[5] !== 32'h0000_1111) begin
        miscompares++;
        $display("FAIL reset_blocks_sw: pc=%0d halted=%b dmem5=%h, expected 0 0 00001111",
                 pc, halted, dut.dmem.mem[5]);
      end
    end
    clr_PC = 1'b1;
    tick();
    vectors++;
    if (pc !== 32'd1 || dut.dmem.mem[5] !== 32'hDEAD_BEEF || instr !== HLT_W) begin
      miscompares++;
      $display("FAIL reset_release_sw: pc=%0d dmem5=%h instr=%h, expected 1 deadbeef fc000000",
               pc, dut.dmem.mem[5], instr);
    end
    clr_PC = 1'b0;
    tick();
    clr_PC = 1'b1;
    vectors++;
    if (pc !== 32'd0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_over_hlt: pc=%0d halted=%b, expected pc=0 halted=0", pc, halted);
    end
  endtask

  task automatic test_factorial();
    logic [31:0] p[$];
    fact_prog(p);
    setup(p);
    dut.dmem.mem[200] = 32'd5;
    dut.dmem.mem[198] = 32'd0;
    repeat (19) tick();
    vectors++;
    if (dut.dmem.mem[198] !== 32'd120 || dut.regs.reg_bank[1] !== 32'd0 ||
        dut.regs.reg_bank[2] !== 32'd120 || pc !== 32'd6 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL factorial: dmem198=%0d R1=%0d R2=%0d pc=%0d halted=%b, expected 120 0 120 6 1",
               dut.dmem.mem[198], dut.regs.reg_bank[1], dut.regs.reg_bank[2], pc, halted);
    end
  endtask

  task automatic test_alu();
    logic [31:0] p[$];
    p = '{enc_i(T_ADDI, 0, 1, 16'd7),     enc_i(T_ADDI, 0, 2, 16'hFFFD),
          enc_r(T_ADD, 1, 2, 3),          enc_r(T_SUB, 1, 2, 4),
          enc_r(T_SLT, 2, 1, 5),          enc_r(T_MUL, 1, 2, 6),
          enc_r(T_AND, 1, 2, 8),          enc_r(T_OR, 1, 2, 9),
          enc_i(T_SLTI, 2, 10, 16'hFFFE), enc_i(T_SUBI, 1, 11, 16'd9),
          enc_r(T_SLT, 1, 2, 12),         HLT_W};
    setup(p);
    repeat (12) tick();
    vectors++;
    if (dut.regs.reg_bank[3] !== 32'd4 || dut.regs.reg_bank[4] !== 32'd10 ||
        dut.regs.reg_bank[5] !== 32'd1 || dut.regs.reg_bank[6] !== 32'hFFFF_FFEB) begin
      miscompares++;
      $display("FAIL alu_add_sub_slt_mul: R3=%h R4=%h R5=%h R6=%h, expected 4 a 1 ffffffeb",
               dut.regs.reg_bank[3], dut.regs.reg_bank[4], dut.regs.reg_bank[5], dut.regs.reg_bank[6]);
    end
    vectors++;
    if (dut.regs.reg_bank[8] !== 32'd5 || dut.regs.reg_bank[9] !== 32'hFFFF_FFFF ||
        dut.regs.reg_bank[10] !== 32'd1 || dut.regs.reg_bank[11] !== 32'hFFFF_FFFE ||
        dut.regs.reg_bank[12] !== 32'd0) begin
      miscompares++;
      $display("FAIL alu_and_or_slti_subi: R8=%h R9=%h R10=%h R11=%h R12=%h, expected 5 ffffffff 1 fffffffe 0",
               dut.regs.reg_bank[8], dut.regs.reg_bank[9], dut.regs.reg_bank[10],
               dut.regs.reg_bank[11], dut.regs.reg_bank[12]);
    end
  endtask

  task automatic test_r0();
    logic [31:0] p[$];
    p = '{enc_i(T_ADDI, 0, 0, 16'd5), enc_r(T_ADD, 0, 0, 7), HLT_W};
    setup(p);
    dut.regs.reg_bank[0] = 32'h0000_0055;
    dut.regs.reg_bank[7] = 32'h0000_1234;
    repeat (3) tick();
    vectors++;
    if (dut.regs.reg_bank[7] !== 32'd0 || pc !== 32'd2 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL r0_reads_zero: R7=%h pc=%0d halted=%b, expected 0 2 1",
               dut.regs.reg_bank[7], pc, halted);
    end
`ifdef MIPS32_DBG_PORT_EN
    dbg_reg_addr = 5'd0;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'd0) begin
      miscompares++;
      $display("FAIL dbg_r0: got %h expected 0", dbg_reg_data);
    end
    dut.regs.reg_bank[13] = 32'hA5A5_0013;
    dbg_reg_addr = 5'd13;
    #1;
    vectors++;
    if (dbg_reg_data !== 32'hA5A5_0013) begin
      miscompares++;
      $display("FAIL dbg_r13: got %h expected a5a50013", dbg_reg_data);
    end
`endif
  endtask

  task automatic test_branch();
    logic [31:0] p[$];
    p = '{enc_i(T_BEQZ, 0, 0, 16'd2), enc_i(T_ADDI, 0, 1, 16'd1),
          enc_i(T_ADDI, 0, 2, 16'd2), enc_i(T_BNEQZ, 0, 0, 16'hFFFF),
          enc_i(T_ADDI, 0, 3, 16'd3), HLT_W};
    setup(p);
    dut.regs.reg_bank[0] = 32'h0000_0099;
    dut.regs.reg_bank[1] = 32'h77;
    dut.regs.reg_bank[2] = 32'h77;
    tick();
    vectors++;
    if (pc !== 32'd3) begin
      miscompares++;
      $display("FAIL beqz_taken: pc=%0d expected 3", pc);
    end
    tick();
    vectors++;
    if (pc !== 32'd4) begin
      miscompares++;
      $display("FAIL bneqz_not_taken: pc=%0d expected 4", pc);
    end
    repeat (2) tick();
    vectors++;
    if (dut.regs.reg_bank[1] !== 32'h77 || dut.regs.reg_bank[2] !== 32'h77 ||
        dut.regs.reg_bank[3] !== 32'd3 || pc !== 32'd5 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_skip: R1=%h R2=%h R3=%h pc=%0d halted=%b, expected 77 77 3 5 1",
               dut.regs.reg_bank[1], dut.regs.reg_bank[2], dut.regs.reg_bank[3], pc, halted);
    end
  endtask

  task automatic test_mem_wrap();
    logic [31:0] p[$];
    p = '{enc_i(T_ADDI, 0, 1, 16'd1031), enc_i(T_ADDI, 0, 2, 16'h005A),
          enc_i(T_SW, 1, 2, 16'd0),       enc_i(T_LW, 0, 3, 16'd7),
          enc_r(T_ADD, 3, 3, 4),          enc_i(T_LW, 0, 5, 16'hFFFF), HLT_W};
    setup(p);
    dut.dmem.mem[1023] = 32'hCAFE_0001;
    repeat (7) tick();
    vectors++;
    if (dut.dmem.mem[7] !== 32'h5A || dut.regs.reg_bank[3] !== 32'h5A ||
        dut.regs.reg_bank[4] !== 32'hB4 || dut.regs.reg_bank[5] !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL mem_wrap_lw_sw: dmem7=%h R3=%h R4=%h R5=%h, expected 5a 5a b4 cafe0001",
               dut.dmem.mem[7], dut.regs.reg_bank[3], dut.regs.reg_bank[4], dut.regs.reg_bank[5]);
    end
  endtask

  task automatic test_halt();
    logic [31:0] p[$];
    p = '{HLT_W, enc_i(T_SW, 0, 1, 16'd0)};
    setup(p);
    dut.dmem.mem[0] = 32'h0BAD_F00D;
    dut.regs.reg_bank[1] = 32'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (pc !== 32'd0 || halted !== 1'b1 || dut.dmem.mem[0] !== 32'h0BAD_F00D) begin
        miscompares++;
        $display("FAIL halt_frozen cyc%0d: pc=%0d halted=%b dmem0=%h, expected 0 1 0badf00d",
                 c, pc, halted, dut.dmem.mem[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] p[$];
    fact_prog(p);
    setup(p);
    dut.dmem.mem[200] = 32'd5;
    dut.dmem.mem[198] = 32'd0;
    repeat (7) tick();
    clr_PC = 1'b0;
    tick();
    clr_PC = 1'b1;
    vectors++;
    if (pc !== 32'd0 || halted !== 1'b0 || dut.dmem.mem[198] !== 32'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: pc=%0d halted=%b dmem198=%0d, expected 0 0 0",
               pc, halted, dut.dmem.mem[198]);
    end
    repeat (19) tick();
    vectors++;
    if (dut.dmem.mem[198] !== 32'd120 || pc !== 32'd6 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_rerun: dmem198=%0d pc=%0d halted=%b, expected 120 6 1",
               dut.dmem.mem[198], pc, halted);
    end
  endtask

  task automatic test_random();
    logic [31:0] p[$];
    logic [5:0]  op;
    logic [15:0] imm;
    for (int prog_i = 0; prog_i < 10; prog_i++) begin
      p.delete();
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 15))
          0: op = T_ADD;  1: op = T_SUB;   2: op = T_AND;   3: op = T_OR;
          4: op = T_SLT;  5: op = T_MUL;   6: op = T_LW;    7: op = T_SW;
          8: op = T_ADDI; 9: op = T_SUBI;  10: op = T_SLTI; 11: op = T_BNEQZ;
          12: op = T_BEQZ; 13: op = 6'd7;  14: op = 6'd40;  default: op = T_ADDI;
        endcase
        if (op == T_BEQZ || op == T_BNEQZ)
          imm = 16'($signed($urandom_range(0, 7)) - 3);
        else if ($urandom_range(0, 1) == 0)
          imm = 16'($urandom_range(0, 30));
        else
          imm = 16'($urandom);
        if (op <= T_MUL)
          p.push_back(enc_r(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7))));
        else
          p.push_back(enc_i(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm));
      end
      p.push_back(HLT_W);
      setup(p);
      for (int c = 0; c < 60; c++) begin
        model_step();
        tick();
        vectors++;
        if (pc !== m_pc || halted !== m_halt || instr !== m_imem[m_pc[9:0]]) begin
          miscompares++;
          $display("FAIL rand%0d_cyc%0d: pc=%0d halted=%b instr=%h, expected %0d %b %h",
                   prog_i, c, pc, halted, instr, m_pc, m_halt, m_imem[m_pc[9:0]]);
        end
      end
      for (int r = 1; r < 32; r++) begin
        vectors++;
        if (dut.regs.reg_bank[r] !== m_regs[r]) begin
          miscompares++;
          $display("FAIL rand%0d_reg%0d: got %h expected %h", prog_i, r,
                   dut.regs.reg_bank[r], m_regs[r]);
        end
      end
      for (int a = 0; a < 1024; a++) begin
        vectors++;
        if (dut.dmem.mem[a] !== m_dmem[a]) begin
          miscompares++;
          $display("FAIL rand%0d_dmem%0d: got %h expected %h", prog_i, a,
                   dut.dmem.mem[a], m_dmem[a]);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_factorial();
    test_alu();
    test_r0();
    test_branch();
    test_mem_wrap();
    test_halt();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
